// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file ALU sequencer: opcodes,
// FSM state type and instruction field positions.
// Optional flag outputs are enabled by defining RF_SEQ_FLAGS_EN.
package rf_seq_pkg;

    localparam int unsigned INSTR_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

    // Low bit of each instruction field; all fields are 2 bits wide.
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned FIELD_W = 2;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/OR on DATA_W operands.
// carry is the ADD carry-out or the SUB borrow (a < b); 0 for logic ops.
module rf_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // Select the operation; arithmetic uses one extra bit for carry/borrow.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND: result = a & b;
            default: result = a | b;
        endcase
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Control/datapath stage for the 4x8 register file: accepts one
// register-register instruction at a time, reads rs1/rs2, computes the ALU
// result and writes it back to rd (IDLE -> READ -> EXEC -> WB).
// Define RF_SEQ_FLAGS_EN to add the registered flag_zero/flag_carry outputs.
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 2
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                instr_valid,
    input  logic [7:0]          instr,
    output logic                instr_ready,
    output logic [IDX_W-1:0]    read_index1,
    output logic [IDX_W-1:0]    read_index2,
    input  logic [DATA_W-1:0]   read_data1,
    input  logic [DATA_W-1:0]   read_data2,
    output logic                write,
    output logic [IDX_W-1:0]    write_index,
    output logic [DATA_W-1:0]   write_data,
    output logic                busy,
    output logic                done
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic                flag_zero,
    output logic                flag_carry
`endif
);

    state_t state, state_next;

    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  result_q;
    logic [DATA_W-1:0]  alu_result;
    logic [1:0]         opcode;

`ifdef RF_SEQ_FLAGS_EN
    logic alu_carry;
`else
    logic alu_carry_unused;
`endif

    assign opcode      = instr_q[OP_LSB +: FIELD_W];
    assign read_index1 = instr_q[RS1_LSB +: IDX_W];
    assign read_index2 = instr_q[RS2_LSB +: IDX_W];

    rf_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (opcode),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
`ifdef RF_SEQ_FLAGS_EN
        .carry  (alu_carry)
`else
        .carry  (alu_carry_unused)
`endif
    );

    // State register; clear forces IDLE from any state.
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/write-port outputs decoded from the state.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        busy        = 1'b0;
        write       = 1'b0;
        done        = 1'b0;
        write_index = '0;
        write_data  = '0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy       = 1'b1;
                state_next = S_WB;
            end
            default: begin
                busy        = 1'b1;
                write       = 1'b1;
                done        = 1'b1;
                write_index = instr_q[RD_LSB +: IDX_W];
                write_data  = result_q;
                state_next  = S_IDLE;
            end
        endcase
    end

    // Datapath registers: capture instruction, latch operands, latch result.
    always_ff @(posedge clock) begin
        if (clear) begin
            instr_q    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result_q   <= '0;
`ifdef RF_SEQ_FLAGS_EN
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                S_READ: begin
                    op_a <= read_data1;
                    op_b <= read_data2;
                end
                S_EXEC: begin
                    result_q   <= alu_result;
`ifdef RF_SEQ_FLAGS_EN
                    flag_zero  <= (alu_result == '0);
                    flag_carry <= alu_carry;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Self-checking bench for rf_alu_sequencer paired with a behavioural 4x8
// register file (negedge write, asynchronous clear that wins over the write).
// Flag checks are compiled in when RF_SEQ_FLAGS_EN is defined.
module tb_rf_alu_sequencer;
    import rf_seq_pkg::*;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       instr_valid = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       instr_ready;
    logic [1:0] read_index1, read_index2;
    logic [7:0] read_data1, read_data2;
    logic       write;
    logic [1:0] write_index;
    logic [7:0] write_data;
    logic       busy, done;
`ifdef RF_SEQ_FLAGS_EN
    logic       flag_zero, flag_carry;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Register file model plus a bench-side preload path.
    logic [7:0] rf [4];
    logic       pl_en = 1'b0;
    logic [1:0] pl_idx = 2'd0;
    logic [7:0] pl_val = 8'h00;

    // Bench's own view of the file contents.
    int mdl [4];

    always #5 clock = ~clock;

    rf_alu_sequencer #(
        .DATA_W (8),
        .IDX_W  (2)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .read_index1 (read_index1),
        .read_index2 (read_index2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write       (write),
        .write_index (write_index),
        .write_data  (write_data),
        .busy        (busy),
        .done        (done)
`ifdef RF_SEQ_FLAGS_EN
        ,
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry)
`endif
    );

    assign read_data1 = rf[read_index1];
    assign read_data2 = rf[read_index2];

    always @(negedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else begin
            if (write) rf[write_index] <= write_data;
            if (pl_en) rf[pl_idx] <= pl_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU from the opcode rules, using plain integer arithmetic.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output bit z, output bit c);
        c = 1'b0;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) > 255; end
            1: begin r = (a - b + 256) % 256; c = (a < b); end
            2: r = a & b;
            default: r = a | b;
        endcase
        z = (r == 0);
    endfunction

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
    endtask

    task automatic preload(input logic [1:0] idx, input logic [7:0] val);
        @(posedge clock);
        #1;
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clock);
        #1 pl_en = 1'b0;
        mdl[idx] = val;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!instr_ready && n < 20);
        chk({tag, "_ready_timeout"}, {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic check_file_zero(input string tag);
        for (int i = 0; i < 4; i++) chk({tag, "_rf_zero"}, {24'd0, rf[i]}, 32'd0);
    endtask

    // Issue one instruction and check the whole READ/EXEC/WB sequence.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [7:0] exp_d, input logic exp_z,
                         input logic exp_c, input string tag);
        int n;
        wait_ready(tag);
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2};
        @(posedge clock);
        #1 instr_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                chk({tag, "_rd_idx1"}, {30'd0, read_index1}, {30'd0, rs1});
                chk({tag, "_rd_idx2"}, {30'd0, read_index2}, {30'd0, rs2});
                chk({tag, "_busy_read"}, {31'd0, busy}, 32'd1);
            end
        end while (!done && n < 10);
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_write"}, {31'd0, write}, 32'd1);
        chk({tag, "_wr_idx"}, {30'd0, write_index}, {30'd0, rd});
        chk({tag, "_wr_data"}, {24'd0, write_data}, {24'd0, exp_d});
        chk({tag, "_ready_wb"}, {31'd0, instr_ready}, 32'd0);
`ifdef RF_SEQ_FLAGS_EN
        chk({tag, "_flag_zero"}, {31'd0, flag_zero}, {31'd0, exp_z});
        chk({tag, "_flag_carry"}, {31'd0, flag_carry}, {31'd0, exp_c});
`else
        if (exp_z === 1'bx || exp_c === 1'bx) $display("note: undefined flag expectation in %s", tag);
`endif
        @(negedge clock);
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_write_drop"}, {31'd0, write}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
        chk({tag, "_rf_rd"}, {24'd0, rf[rd]}, {24'd0, exp_d});
        mdl[rd] = exp_d;
    endtask

    typedef struct {
        logic [1:0] op, rd, rs1, rs2;
        logic [7:0] a, b, exp_d;
        logic       exp_z, exp_c;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int ndone, t, t1, t2, nwr, r;
        bit z, c;
        logic [7:0] d1, d2;
        logic [1:0] op, rd, rs1, rs2;

        tbl[0] = '{OP_ADD, 2'd0, 2'd1, 2'd2, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{OP_SUB, 2'd3, 2'd2, 2'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        tbl[2] = '{OP_ADD, 2'd2, 2'd0, 2'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{OP_OR,  2'd1, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{OP_AND, 2'd0, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{OP_SUB, 2'd1, 2'd1, 2'd2, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{OP_ADD, 2'd3, 2'd3, 2'd3, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

        // Reset state.
        do_clear();
        @(negedge clock);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_wr_idx", {30'd0, write_index}, 32'd0);
        chk("rst_wr_data", {24'd0, write_data}, 32'd0);
        chk("rst_rd_idx1", {30'd0, read_index1}, 32'd0);
        chk("rst_rd_idx2", {30'd0, read_index2}, 32'd0);
`ifdef RF_SEQ_FLAGS_EN
        chk("rst_flag_zero", {31'd0, flag_zero}, 32'd0);
        chk("rst_flag_carry", {31'd0, flag_carry}, 32'd0);
`endif
        check_file_zero("rst");

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            preload(tbl[i].rs1, tbl[i].a);
            if (tbl[i].rs2 != tbl[i].rs1) preload(tbl[i].rs2, tbl[i].b);
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                  tbl[i].exp_d, tbl[i].exp_z, tbl[i].exp_c, $sformatf("tbl%0d", i));
        end

        // Back-to-back dependent ADD r1,r1,r1 with instr_valid held high.
        preload(2'd1, 8'h02);
        wait_ready("dep");
        instr_valid = 1'b1;
        instr = {OP_ADD, 2'd1, 2'd1, 2'd1};
        ndone = 0; t = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        while (ndone < 2 && t < 40) begin
            @(negedge clock);
            t++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = t; d1 = write_data; end
                else begin t2 = t; d2 = write_data; instr_valid = 1'b0; end
            end
        end
        instr_valid = 1'b0;
        chk("dep_count", ndone, 2);
        chk("dep_first", {24'd0, d1}, 32'h04);
        chk("dep_second", {24'd0, d2}, 32'h08);
        chk("dep_spacing", t2 - t1, 4);
        @(negedge clock);
        chk("dep_rf1", {24'd0, rf[1]}, 32'h08);
        mdl[1] = 8'h08;
        @(negedge clock);
        chk("dep_no_third", {31'd0, busy}, 32'd0);

        // clear while in EXEC.
        preload(2'd2, 8'h11);
        preload(2'd3, 8'h22);
        wait_ready("clr_exec");
        instr_valid = 1'b1;
        instr = {OP_ADD, 2'd0, 2'd2, 2'd3};
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(posedge clock);
        #1 clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        @(negedge clock);
        chk("clr_exec_ready", {31'd0, instr_ready}, 32'd1);
        chk("clr_exec_busy", {31'd0, busy}, 32'd0);
        chk("clr_exec_write", {31'd0, write}, 32'd0);
        chk("clr_exec_rd_idx1", {30'd0, read_index1}, 32'd0);
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (write || done) nwr++;
        end
        chk("clr_exec_stale_write", nwr, 0);
        check_file_zero("clr_exec");

        // clear while in WB: file clear wins over the negedge write.
        preload(2'd1, 8'h40);
        preload(2'd2, 8'h01);
        wait_ready("clr_wb");
        instr_valid = 1'b1;
        instr = {OP_OR, 2'd3, 2'd1, 2'd2};
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("clr_wb_in_wb", {31'd0, write}, 32'd1);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
        @(negedge clock);
        chk("clr_wb_write", {31'd0, write}, 32'd0);
        chk("clr_wb_done", {31'd0, done}, 32'd0);
        chk("clr_wb_ready", {31'd0, instr_ready}, 32'd1);
        chk("clr_wb_wr_data", {24'd0, write_data}, 32'd0);
        check_file_zero("clr_wb");

        // Randomized instructions against the reference model.
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            rd  = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3));
            rs2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) preload(rs1, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) preload(rs2, 8'($urandom_range(0, 255)));
            ref_alu(int'(op), mdl[rs1], mdl[rs2], r, z, c);
            issue(op, rd, rs1, rs2, 8'(r), z, c, $sformatf("rnd%0d", i));
        end

        // File contents agree with the model at the end.
        for (int i = 0; i < 4; i++) chk("final_rf", {24'd0, rf[i]}, mdl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
